psum_stream_out: RTL and testbench



---
 rtl/psum_stream_pkg.sv | 7 +
 rtl/psum_word_buffer.sv | 36 +++
 rtl/psum_stream_out.sv | 91 +++++++++
 tb/tb_psum_stream_out.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/psum_stream_pkg.sv
// psum_stream_pkg: shared lane geometry and FSM state type for the psum output stream
package psum_stream_pkg;
  localparam int LANE_WIDTH = 32;
  localparam int LANES = 40;
  localparam int LANE_IDX_W = $clog2(LANES);
  typedef enum logic {S_IDLE, S_SEND} state_t;
endpackage

// File: rtl/psum_word_buffer.sv
// psum_word_buffer: 2-entry wide-word FIFO; a push while full is taken when a pop frees the slot
module psum_word_buffer #(
  parameter int WIDTH = 1280
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem [2];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= !wr_ptr;
      if (do_pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/psum_stream_out.sv
// psum_stream_out: serialises buffered 1280-bit psum words into 32-bit AXI4-Stream lanes with per-layer TLAST.
// Optional PSUM_RELU_EN clamps negative lanes to zero at the output mux.
module psum_stream_out import psum_stream_pkg::*; #(
  parameter int PSUM_WIDTH = LANES * LANE_WIDTH,
  parameter int C_M_AXIS_TDATA_WIDTH = LANE_WIDTH,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              layer_start,
  input  logic [FRAME_CNT_WIDTH-1:0]        frame_words,
  input  logic [PSUM_WIDTH-1:0]             psum_in,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  output logic                              frame_done,
  output logic                              busy
);
  state_t state, state_nxt;
  logic [LANE_IDX_W-1:0] lane_idx;
  logic [FRAME_CNT_WIDTH-1:0] word_cnt, frame_words_q;
  logic [PSUM_WIDTH-1:0] head;
  logic [LANES-1:0][LANE_WIDTH-1:0] head_lanes;
  logic [LANE_WIDTH-1:0] lane, lane_out;
  logic full, empty, push, pop, beat, last_lane;
  logic [1:0] count, cnt_nxt;

  psum_word_buffer #(.WIDTH(PSUM_WIDTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (psum_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_lanes = head;
  assign lane = head_lanes[lane_idx];
`ifdef PSUM_RELU_EN
  assign lane_out = lane[LANE_WIDTH-1] ? '0 : lane;
`else
  assign lane_out = lane;
`endif

  assign M_AXIS_TSTRB = '1;
  assign M_AXIS_TVALID = state == S_SEND;
  assign M_AXIS_TDATA = M_AXIS_TVALID ? lane_out : '0;
  assign last_lane = lane_idx == LANE_IDX_W'(LANES - 1);
  assign M_AXIS_TLAST = M_AXIS_TVALID && last_lane && frame_words_q != '0 && word_cnt == frame_words_q - 1'b1;
  assign beat = M_AXIS_TVALID && M_AXIS_TREADY;
  assign pop = beat && last_lane;
  assign push = psum_valid && psum_ready && (!full || pop);
  assign cnt_nxt = count + 2'(push) - 2'(pop);
  assign busy = count != 2'd0;

  always_comb begin
    state_nxt = state;
    state_nxt = (state == S_IDLE) ? ((push || !empty) ? S_SEND : S_IDLE)
                                  : ((pop && cnt_nxt == 2'd0) ? S_IDLE : S_SEND);
  end

  // ready is registered from the next-state count, so it is never stale when the buffer fills
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      lane_idx <= '0;
      word_cnt <= '0;
      frame_words_q <= '0;
      psum_ready <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      psum_ready <= cnt_nxt != 2'd2;
      frame_done <= beat && M_AXIS_TLAST;
      if (beat) lane_idx <= last_lane ? '0 : lane_idx + 1'b1;
      if (layer_start) begin
        frame_words_q <= frame_words;
        word_cnt <= '0;
      end else if (pop) begin
        word_cnt <= M_AXIS_TLAST ? '0 : word_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_psum_stream_out.sv
// tb_psum_stream_out: directed bench for psum_stream_out with a beat scoreboard and AXI hold checks
module tb_psum_stream_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic layer_start = 1'b0;
  logic [15:0] frame_words = '0;
  logic [1279:0] psum_in = '0;
  logic psum_valid = 1'b0;
  logic psum_ready;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0] M_AXIS_TSTRB;
  logic M_AXIS_TVALID;
  logic M_AXIS_TREADY = 1'b1;
  logic M_AXIS_TLAST;
  logic frame_done;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];
  int beats = 0, bubbles = 0, fd_cnt = 0, cyc = 0, last_cyc = -10;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [31:0] prev_d = '0;
  bit rand_rdy = 1'b0;

  psum_stream_out dut (
    .clk           (clk),
    .rst           (rst),
    .layer_start   (layer_start),
    .frame_words   (frame_words),
    .psum_in       (psum_in),
    .psum_valid    (psum_valid),
    .psum_ready    (psum_ready),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef PSUM_RELU_EN
    return x[31] ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [1279:0] make_word(input int base);
    logic [1279:0] w;
    for (int k = 0; k < 40; k++) w[32*k +: 32] = 32'(base + k);
    return w;
  endfunction

  always @(posedge clk) begin
    #1;
    M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // stream monitor: handshake seen here completes on the following rising edge
  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_tvalid", M_AXIS_TVALID, 1);
        check("hold_tdata", M_AXIS_TDATA, prev_d);
        check("hold_tlast", M_AXIS_TLAST, prev_l);
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beats++;
        if (M_AXIS_TLAST) last_cyc = cyc;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("tdata", M_AXIS_TDATA, e[31:0]);
          check("tlast", M_AXIS_TLAST, e[32]);
        end
      end
      if (!M_AXIS_TVALID && exp_q.size() != 0) bubbles++;
      if (frame_done) begin
        fd_cnt++;
        check("done_latency", 64'(cyc - last_cyc), 1);
      end
      prev_v = M_AXIS_TVALID;
      prev_r = M_AXIS_TREADY;
      prev_d = M_AXIS_TDATA;
      prev_l = M_AXIS_TLAST;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [15:0] n);
    frame_words = n;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic push_word(input logic [1279:0] w, input bit lastw);
    bit acc = 1'b0;
    psum_in = w;
    psum_valid = 1'b1;
    for (int t = 0; t < 2000 && !acc; t++) begin
      acc = psum_ready;
      tick();
    end
    psum_valid = 1'b0;
    check("push_accepted", acc, 1);
    for (int k = 0; k < 40; k++) exp_q.push_back({lastw && k == 39, relu(w[32*k +: 32])});
  endtask

  task automatic drain();
    for (int t = 0; t < 4000 && exp_q.size() != 0; t++) tick();
    check("drain_done", exp_q.size() == 0, 1);
    repeat (3) tick();
    check("idle_tvalid", M_AXIS_TVALID, 0);
    check("idle_busy", busy, 0);
    check("bubbles", bubbles, 0);
  endtask

  initial begin
    logic [1279:0] w;
    int b0;
    repeat (3) tick();
    check("rst_ready", psum_ready, 1);
    check("rst_tvalid", M_AXIS_TVALID, 0);
    check("rst_tlast", M_AXIS_TLAST, 0);
    check("rst_tdata", M_AXIS_TDATA, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("tstrb", M_AXIS_TSTRB, 4'hF);
    rst = 1'b0;
    tick();

    start_layer(16'd1);
    b0 = beats;
    push_word(make_word(1), 1'b1);
    check("lat_tvalid", M_AXIS_TVALID, 1);
    check("lat_tdata", M_AXIS_TDATA, 1);
    check("busy_on", busy, 1);
    drain();
    check("single_beats", beats - b0, 40);
    check("single_done", fd_cnt, 1);

    start_layer(16'd3);
    b0 = beats;
    push_word(make_word(1001), 1'b0);
    push_word(make_word(2001), 1'b0);
    check("ready_full", psum_ready, 0);
    push_word(make_word(3001), 1'b1);
    drain();
    check("b2b_beats", beats - b0, 120);
    check("b2b_done", fd_cnt, 2);

    rand_rdy = 1'b1;
    start_layer(16'd2);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 40; k++) w[32*k +: 32] = $urandom;
      push_word(w, n == 1);
    end
    drain();
    rand_rdy = 1'b0;
    tick();
    check("bp_done", fd_cnt, 3);

    start_layer(16'd0);
    w = '0;
    w[31:0] = 32'hFFFF_FFF6;
    w[63:32] = 32'd7;
    push_word(w, 1'b0);
`ifdef PSUM_RELU_EN
    check("relu_lane0", M_AXIS_TDATA, 0);
`else
    check("relu_lane0", M_AXIS_TDATA, 32'hFFFF_FFF6);
`endif
    tick();
    check("relu_lane1", M_AXIS_TDATA, 7);
    drain();

    b0 = beats;
    push_word(make_word(5000), 1'b0);
    push_word(make_word(6000), 1'b0);
    drain();
    check("unbounded_beats", beats - b0, 80);
    check("unbounded_done", fd_cnt, 3);

    start_layer(16'd5);
    b0 = beats;
    push_word(make_word(100), 1'b0);
    for (int t = 0; t < 200 && beats - b0 < 16; t++) tick();
    check("pre_reset_beats", beats - b0, 16);
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", M_AXIS_TVALID, 0);
    check("mid_rst_ready", psum_ready, 1);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    push_word(make_word(200), 1'b0);
    check("restart_tdata", M_AXIS_TDATA, 200);
    drain();
    check("final_done", fd_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
